multiword_adder_ctrl: RTL

//   Sequencer that performs a WORDS*SIZE-bit add/subtract using one SIZE-bit ripple_carry_adder instance.
//   It processes one SIZE-bit chunk per clock, LSB chunk first, and chains the carry through a register.

---
 rtl/multiword_adder_ctrl_if.sv | 29 ++
 rtl/multiword_adder_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multiword_adder_ctrl_if.sv
// Operand/result handshake bundle for the multiword adder sequencer.
// The producer/consumer side uses the master modport, the sequencer the slave.
interface multiword_adder_ctrl_if #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WORDS*SIZE-1:0] a_in;
  logic [WORDS*SIZE-1:0] b_in;
  logic                  cin;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORDS*SIZE-1:0] sum_out;
  logic                  cout_out;
  logic                  ovf_out;
  logic                  busy;

  modport master (
    output in_valid, a_in, b_in, cin, sub, out_ready,
    input  in_ready, out_valid, sum_out, cout_out, ovf_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, cin, sub, out_ready,
    output in_ready, out_valid, sum_out, cout_out, ovf_out, busy
  );
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Multiword add/subtract sequencer: one narrow ripple-carry adder is reused
// WORDS times, LSB chunk first, with the inter-chunk carry held in a register.
module ripple_carry_adder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            cin_i,
  output logic [SIZE-1:0] s_o,
  output logic            cout_o,
  output logic            ovf_o
);
  logic            carry_s;
  logic [SIZE-1:0] bit_cout_s;

  // Classic ripple chain; the carries out of the top two bits give signed overflow.
  always_comb begin
    carry_s    = cin_i;
    s_o        = '0;
    bit_cout_s = '0;
    for (int i = 0; i < SIZE; i++) begin
      s_o[i]        = a_i[i] ^ b_i[i] ^ carry_s;
      bit_cout_s[i] = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
      carry_s       = bit_cout_s[i];
    end
    cout_o = bit_cout_s[SIZE-1];
    ovf_o  = bit_cout_s[SIZE-1] ^ bit_cout_s[SIZE-2];
  end
endmodule

module multiword_adder_ctrl #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input logic                   clk,
  input logic                   rst,
  multiword_adder_ctrl_if.slave bus
);
  localparam int W    = WORDS * SIZE;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic            in_ready_s;
  logic [SIZE-1:0] chunk_a_s;
  logic [SIZE-1:0] chunk_b_s;
  logic [SIZE-1:0] adder_sum_s;
  logic            adder_cout_s;
  logic            adder_ovf_s;

  // B is stored already inverted for subtraction, so the adder never sees 'sub'.
  assign chunk_a_s = a_q[idx_q*SIZE +: SIZE];
  assign chunk_b_s = b_q[idx_q*SIZE +: SIZE];

  ripple_carry_adder #(.SIZE(SIZE)) u_rca (
    .a_i    (chunk_a_s),
    .b_i    (chunk_b_s),
    .cin_i  (carry_q),
    .s_o    (adder_sum_s),
    .cout_o (adder_cout_s),
    .ovf_o  (adder_ovf_s)
  );

  assign in_ready_s    = (state_q == IDLE) && !rst;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum_out   = sum_q;
  assign bus.cout_out  = cout_q;
  assign bus.ovf_out   = ovf_q;

  // Next-state logic: capture operands in IDLE, one chunk per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_s) begin
          a_d     = bus.a_in;
          b_d     = bus.sub ? ~bus.b_in : bus.b_in;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*SIZE +: SIZE] = adder_sum_s;
        carry_d = adder_cout_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = adder_cout_s;
          ovf_d   = adder_ovf_s;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation and clears every result field.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
